// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter: FSM state encoding
// and the owner encoding used by the grant logic and the owner output.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_e;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Combinational 2-way round-robin pick between the I-side and D-side requests.
// On a tie the side that did not own the last grant wins.
module mem_port_arbiter_rr
    import mem_port_arbiter_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last,
    output logic gnt_valid,
    output logic gnt
);

    always_comb begin
        gnt_valid = req_i || req_d;
        if (req_i && req_d) begin
            gnt = (last == OWNER_I) ? OWNER_D : OWNER_I;
        end else begin
            gnt = req_d ? OWNER_D : OWNER_I;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between I-side line fills and D-side fills or
// single-word writes; fixed-latency access, captured line, one-cycle done pulse.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WORD_SIZE  = 16,
    parameter int LINE_WORDS = 4,
    parameter int LATENCY    = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            i_req,
    input  logic [WORD_SIZE-1:0]            i_addr,
    input  logic                            i_cancel,
    output logic                            i_done,
    output logic [LINE_WORDS*WORD_SIZE-1:0] i_line,
    input  logic                            d_req,
    input  logic                            d_we,
    input  logic [WORD_SIZE-1:0]            d_addr,
    input  logic [WORD_SIZE-1:0]            d_wdata,
    output logic                            d_done,
    output logic [LINE_WORDS*WORD_SIZE-1:0] d_line,
    output logic                            mem_read,
    output logic                            mem_write,
    output logic [WORD_SIZE-1:0]            mem_addr,
    output logic [WORD_SIZE-1:0]            mem_wdata,
    input  logic [LINE_WORDS*WORD_SIZE-1:0] mem_rdata,
    output logic                            busy,
    output logic                            owner
);

    localparam int LINE_W = LINE_WORDS * WORD_SIZE;
    localparam int CNT_W  = $clog2(LATENCY) + 1;
    localparam logic [CNT_W-1:0]     CNT_INIT = CNT_W'(LATENCY - 1);
    localparam logic [WORD_SIZE-1:0] OFF_MASK = WORD_SIZE'(LINE_WORDS - 1);

    function automatic logic [WORD_SIZE-1:0] line_base(input logic [WORD_SIZE-1:0] a);
        line_base = a & ~OFF_MASK;
    endfunction

    arb_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 last_owner_q, last_owner_d;
    logic                 owner_q, owner_d;
    logic                 we_q, we_d;
    logic                 drop_q, drop_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0]    i_line_q, i_line_d;
    logic [LINE_W-1:0]    d_line_q, d_line_d;

    logic i_valid;
    logic gnt_valid;
    logic gnt;
    logic i_cancel_hit;

    // A cancelled I request never competes for the port.
    assign i_valid = i_req && !i_cancel;

    mem_port_arbiter_rr u_rr (
        .req_i     (i_valid),
        .req_d     (d_req),
        .last      (last_owner_q),
        .gnt_valid (gnt_valid),
        .gnt       (gnt)
    );

    assign i_cancel_hit = i_cancel && (owner_q == OWNER_I);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        we_d         = we_q;
        drop_d       = drop_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        i_line_d     = i_line_q;
        d_line_d     = d_line_q;
        unique case (state_q)
            ARB_IDLE: begin
                drop_d = 1'b0;
                if (gnt_valid) begin
                    owner_d = gnt;
                    cnt_d   = CNT_INIT;
                    state_d = ARB_ACCESS;
                    if (gnt == OWNER_D) begin
                        we_d    = d_we;
                        addr_d  = d_we ? d_addr : line_base(d_addr);
                        wdata_d = d_wdata;
                    end else begin
                        we_d   = 1'b0;
                        addr_d = line_base(i_addr);
                    end
                end
            end
            ARB_ACCESS: begin
                if (i_cancel_hit) begin
                    drop_d = 1'b1;
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    state_d = ARB_RESP;
                    // A fill cancelled up to and including this cycle leaves i_line untouched.
                    if (!we_q) begin
                        if (owner_q == OWNER_D) begin
                            d_line_d = mem_rdata;
                        end else if (!drop_q && !i_cancel_hit) begin
                            i_line_d = mem_rdata;
                        end
                    end
                end
            end
            ARB_RESP: begin
                last_owner_d = owner_q;
                drop_d       = 1'b0;
                state_d      = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ARB_IDLE;
            cnt_q        <= '0;
            last_owner_q <= OWNER_I;
            owner_q      <= OWNER_I;
            we_q         <= 1'b0;
            drop_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            i_line_q     <= '0;
            d_line_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            drop_q       <= drop_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            i_line_q     <= i_line_d;
            d_line_q     <= d_line_d;
        end
    end

    assign busy      = (state_q != ARB_IDLE);
    assign mem_read  = (state_q == ARB_ACCESS) && !we_q;
    assign mem_write = (state_q == ARB_ACCESS) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_done    = (state_q == ARB_RESP) && (owner_q == OWNER_I) && !drop_q && !i_cancel;
    assign d_done    = (state_q == ARB_RESP) && (owner_q == OWNER_D);
    assign i_line    = i_line_q;
    assign d_line    = d_line_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected accesses and done pulses are
// queued when stimulus is driven and matched when the DUT produces them.
module tb_mem_port_arbiter;

    localparam int LAT = 4;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } acc_t;

    typedef struct {
        logic        side;
        logic [63:0] line;
        int          cyc;
    } done_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_req, i_cancel, d_req, d_we;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_done, d_done, mem_read, mem_write, busy, owner;
    logic [63:0] i_line, d_line, mem_rdata;
    logic [15:0] mem_addr, mem_wdata;

    logic        i1_req, i1_cancel, d1_req, d1_we;
    logic [15:0] i1_addr, d1_addr, d1_wdata;
    logic        i1_done, d1_done, mem_read1, mem_write1, busy1, owner1;
    logic [63:0] i1_line, d1_line, mem_rdata1;
    logic [15:0] mem_addr1, mem_wdata1;

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    run_len = 0;
    acc_t  acc_q[$];
    done_t done_q[$];
    acc_t  cur;
    logic [63:0] exp_iline, exp_dline;

    function automatic logic [63:0] line_of(input logic [15:0] a);
        if (a == 16'h0010) return 64'h4444_3333_2222_1111;
        return {16'(a + 16'd3), 16'(a + 16'd2), 16'(a + 16'd1), a} ^ 64'hA5A5_0F0F_5A5A_F0F0;
    endfunction

    always_comb mem_rdata  = line_of(mem_addr);
    always_comb mem_rdata1 = line_of(mem_addr1);

    mem_port_arbiter #(.WORD_SIZE(16), .LINE_WORDS(4), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_cancel(i_cancel), .i_done(i_done), .i_line(i_line),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_line(d_line),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    mem_port_arbiter #(.WORD_SIZE(16), .LINE_WORDS(4), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .i_req(i1_req), .i_addr(i1_addr), .i_cancel(i1_cancel), .i_done(i1_done), .i_line(i1_line),
        .d_req(d1_req), .d_we(d1_we), .d_addr(d1_addr), .d_wdata(d1_wdata),
        .d_done(d1_done), .d_line(d1_line),
        .mem_read(mem_read1), .mem_write(mem_write1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
        .busy(busy1), .owner(owner1)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit side, input int max);
        bit seen = 1'b0;
        for (int n = 0; n < max && !seen; n++) begin
            @(negedge clk);
            if (side ? d_done : i_done) seen = 1'b1;
        end
        if (side) begin
            chk("d_done_seen", seen, 1);
            d_req = 1'b0;
        end else begin
            chk("i_done_seen", seen, 1);
            i_req = 1'b0;
        end
    endtask

    // Access and completion monitor for the main instance.
    always @(negedge clk) begin
        done_t e;
        if (!reset_n) begin
            run_len = 0;
        end else begin
            chk("strobe_excl", mem_read & mem_write, 0);
            chk("done_excl", i_done & d_done, 0);
            if (mem_read || mem_write) begin
                if (run_len == 0) begin
                    chk("acc_expected", acc_q.size() > 0, 1);
                    if (acc_q.size() > 0) begin
                        cur = acc_q.pop_front();
                        chk("acc_we", mem_write, cur.we);
                        chk("acc_addr", mem_addr, cur.addr);
                        if (cur.we) chk("acc_wdata", mem_wdata, cur.wdata);
                    end
                end else begin
                    chk("acc_addr_stable", mem_addr, cur.addr);
                end
                run_len++;
            end else if (run_len != 0) begin
                chk("strobe_len", run_len, LAT);
                run_len = 0;
            end
            if (i_done || d_done) begin
                chk("done_expected", done_q.size() > 0, 1);
                if (done_q.size() > 0) begin
                    e = done_q.pop_front();
                    chk("done_side", d_done, e.side);
                    chk("done_cycle", cyc, e.cyc);
                    chk("done_owner", owner, e.side);
                    chk("done_busy", busy, 1);
                    if (e.side) chk("d_line", d_line, e.line);
                    else        chk("i_line", i_line, e.line);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        reset_n = 1'b0;
        i_req = 0; i_cancel = 0; i_addr = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        i1_req = 0; i1_cancel = 0; i1_addr = 0;
        d1_req = 0; d1_we = 0; d1_addr = 0; d1_wdata = 0;
        exp_iline = '0;
        exp_dline = '0;
        repeat (3) step();
        chk("rst_strobes", {mem_read, mem_write, i_done, d_done, busy, owner}, 6'b0);
        chk("rst_lines", i_line | d_line, 0);
        chk("rst_addr_wdata", {mem_addr, mem_wdata}, 0);
        reset_n = 1'b1;

        // Lone I fill.
        step();
        c0 = cyc;
        i_addr = 16'h0013; i_req = 1'b1;
        exp_iline = 64'h4444_3333_2222_1111;
        acc_q.push_back('{we: 1'b0, addr: 16'h0010, wdata: 16'h0});
        done_q.push_back('{side: 1'b0, line: exp_iline, cyc: c0 + LAT + 1});
        wait_done(0, 20);

        // Lone D write; d_line stays at its reset value.
        step();
        c0 = cyc;
        d_we = 1'b1; d_addr = 16'h0042; d_wdata = 16'hBEEF; d_req = 1'b1;
        acc_q.push_back('{we: 1'b1, addr: 16'h0042, wdata: 16'hBEEF});
        done_q.push_back('{side: 1'b1, line: exp_dline, cyc: c0 + LAT + 1});
        wait_done(1, 20);

        // Simultaneous requests after reset: D first, then alternating grants.
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        exp_iline = '0;
        exp_dline = '0;
        step();
        c0 = cyc;
        acc_q.push_back('{we: 1'b1, addr: 16'h0200, wdata: 16'h1234});
        acc_q.push_back('{we: 1'b0, addr: 16'h0120, wdata: 16'h0});
        acc_q.push_back('{we: 1'b0, addr: 16'h0308, wdata: 16'h0});
        acc_q.push_back('{we: 1'b0, addr: 16'h0144, wdata: 16'h0});
        done_q.push_back('{side: 1'b1, line: 64'h0, cyc: c0 + 5});
        done_q.push_back('{side: 1'b0, line: line_of(16'h0120), cyc: c0 + 11});
        done_q.push_back('{side: 1'b1, line: line_of(16'h0308), cyc: c0 + 17});
        done_q.push_back('{side: 1'b0, line: line_of(16'h0144), cyc: c0 + 23});
        exp_iline = line_of(16'h0144);
        exp_dline = line_of(16'h0308);
        fork
            begin
                d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234; d_req = 1'b1;
                wait_done(1, 30);
                step();
                d_we = 1'b0; d_addr = 16'h030A; d_req = 1'b1;
                wait_done(1, 30);
            end
            begin
                i_addr = 16'h0120; i_req = 1'b1;
                wait_done(0, 30);
                step();
                i_addr = 16'h0146; i_req = 1'b1;
                wait_done(0, 30);
            end
        join

        // I fill cancelled in its 2nd access cycle; pending D write goes next.
        step();
        c0 = cyc;
        i_addr = 16'h0050; i_req = 1'b1;
        acc_q.push_back('{we: 1'b0, addr: 16'h0050, wdata: 16'h0});
        acc_q.push_back('{we: 1'b1, addr: 16'h0060, wdata: 16'h7777});
        done_q.push_back('{side: 1'b1, line: exp_dline, cyc: c0 + 11});
        step();
        d_we = 1'b1; d_addr = 16'h0060; d_wdata = 16'h7777; d_req = 1'b1;
        step();
        i_cancel = 1'b1; i_req = 1'b0;
        step();
        i_cancel = 1'b0;
        wait_done(1, 30);
        chk("i_line_kept", i_line, exp_iline);

        // Reset in the 3rd access cycle of a D fill.
        step();
        d_we = 1'b0; d_addr = 16'h0077; d_req = 1'b1;
        acc_q.push_back('{we: 1'b0, addr: 16'h0074, wdata: 16'h0});
        repeat (3) step();
        chk("pre_rst_read", mem_read, 1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_ctl", {mem_read, mem_write, i_done, d_done, busy, owner}, 6'b0);
        chk("rst_mid_addr", mem_addr, 0);
        chk("rst_mid_lines", i_line | d_line, 0);
        d_req = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        step();
        c0 = cyc;
        d_we = 1'b0; d_addr = 16'h0077; d_req = 1'b1;
        acc_q.push_back('{we: 1'b0, addr: 16'h0074, wdata: 16'h0});
        done_q.push_back('{side: 1'b1, line: line_of(16'h0074), cyc: c0 + LAT + 1});
        wait_done(1, 20);

        // Single-cycle latency build.
        step();
        d1_we = 1'b0; d1_addr = 16'h0035; d1_req = 1'b1;
        @(negedge clk);
        chk("l1_idle_read", {mem_read1, busy1}, 2'b00);
        @(negedge clk);
        chk("l1_access_read", mem_read1, 1);
        chk("l1_access_addr", mem_addr1, 16'h0034);
        chk("l1_access_done", d1_done, 0);
        @(negedge clk);
        chk("l1_resp_read", mem_read1, 0);
        chk("l1_resp_done", d1_done, 1);
        chk("l1_resp_line", d1_line, line_of(16'h0034));
        chk("l1_resp_owner", owner1, 1);
        d1_req = 1'b0;
        @(negedge clk);
        chk("l1_after_done", {d1_done, busy1, i1_done, mem_write1}, 4'b0);
        chk("l1_i_side", {i1_line, mem_wdata1}, 0);

        repeat (3) step();
        chk("acc_q_drained", acc_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
